// File: rtl/mp_alu_pkg.sv
// Shared op codes, FSM states and flag bit positions for the byte-serial multi-precision ALU.
// Optional multiply support is selected with the MP_ALU_MUL_EN macro.
package mp_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam int unsigned FL_C = 0;
  localparam int unsigned FL_Z = 1;
  localparam int unsigned FL_N = 2;
  localparam int unsigned FL_V = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StExec,
    StDrain
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
`ifdef MP_ALU_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_CMP;
`endif
  endfunction

endpackage

// File: rtl/mp_alu_core.sv
// Combinational datapath: computes result and {V,N,Z,C} at the width selected by mask.
// Operands arrive zero-filled above the active width.
module mp_alu_core
  import mp_alu_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 4,
  localparam int unsigned MaxW = MAX_BYTES * 8,
  localparam int unsigned SW = $clog2(MaxW)
) (
  input  logic [MaxW-1:0] a,
  input  logic [MaxW-1:0] b,
  input  logic [3:0]      op,
  input  logic [MaxW-1:0] mask,
  input  logic [SW-1:0]   sh_mask,
  output logic [MaxW-1:0] res,
  output logic [3:0]      flags
);

  logic [MaxW-1:0] msb;
  logic [MaxW:0]   sum;
  logic [MaxW:0]   diff;
  logic [SW-1:0]   shamt;
  logic            sa, sb, sr_add, sr_sub, lt, eq;

  always_comb begin
    msb    = mask ^ (mask >> 1);
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    shamt  = b[SW-1:0] & sh_mask;
    sa     = |(a & msb);
    sb     = |(b & msb);
    sr_add = |(sum[MaxW-1:0] & msb);
    sr_sub = |(diff[MaxW-1:0] & msb);
    lt     = a < b;
    eq     = a == b;
    res    = '0;
    flags  = '0;
    case (op)
      OP_ADD: begin
        res         = sum[MaxW-1:0] & mask;
        // carry lives one bit above the active msb
        flags[FL_C] = |(sum & {msb, 1'b0});
        flags[FL_V] = (sa == sb) && (sr_add != sa);
      end
      OP_SUB: begin
        res         = diff[MaxW-1:0] & mask;
        flags[FL_C] = lt;
        flags[FL_V] = (sa != sb) && (sr_sub != sa);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_SHL: res = (a << shamt) & mask;
      OP_SHR: res = a >> shamt;
      OP_CMP: begin
        res         = eq ? '0 : mask;
        flags[FL_C] = lt;
        flags[FL_Z] = eq;
        flags[FL_N] = (sa != sb) ? sa : lt;
      end
      default: res = '0;
    endcase
    if (op != OP_CMP) begin
      flags[FL_Z] = (res == '0);
      flags[FL_N] = |(res & msb);
    end
  end

endmodule

// File: rtl/mp_alu_stream.sv
// Byte-serial multi-precision ALU: operands stream in LSB-first, result streams out with out_last.
// Define MP_ALU_MUL_EN to add op 8 (MUL) as a multi-cycle shift-add in EXEC.
module mp_alu_stream
  import mp_alu_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned PREC_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [PREC_W-1:0] prec,
  input  logic [3:0]        op,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              err
);

  localparam int unsigned MaxW = MAX_BYTES * 8;
  localparam int unsigned SW   = $clog2(MaxW);
  localparam int unsigned CW   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  state_e            state_q, state_d;
  logic [PREC_W-1:0] prec_q, prec_d;
  logic [3:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MaxW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]        flags_q, flags_d;
  logic              err_q, err_d;

  int unsigned       nbytes;
  logic [MaxW-1:0]   mask;
  logic [SW-1:0]     sh_mask;
  logic              in_fire, out_fire, last_byte, prec_ok;
  logic [MaxW-1:0]   core_res;
  logic [3:0]        core_flags;

`ifdef MP_ALU_MUL_EN
  logic [2*MaxW-1:0] mul_acc_q, mul_acc_d, mul_add;
  logic [SW-1:0]     mul_idx_q, mul_idx_d;
  logic [MaxW-1:0]   msb;
`endif

  mp_alu_core #(
    .MAX_BYTES(MAX_BYTES)
  ) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .mask   (mask),
    .sh_mask(sh_mask),
    .res    (core_res),
    .flags  (core_flags)
  );

  always_comb begin
    nbytes  = 32'd1 << prec_q;
    sh_mask = SW'((nbytes << 3) - 32'd1);
    mask    = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (i < int'(nbytes)) mask[8*i +: 8] = 8'hFF;
    end
    prec_ok   = (32'd1 << prec) <= MAX_BYTES;
    last_byte = (32'(cnt_q) == nbytes - 32'd1);
    in_ready  = (state_q == StIdle) || (state_q == StLoadA) || (state_q == StLoadB);
    out_valid = (state_q == StDrain);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    out_last  = out_valid && last_byte;
    out_data  = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (out_valid && (i == int'(cnt_q))) out_data = res_q[8*i +: 8];
    end
    busy  = (state_q != StIdle);
    flags = flags_q;
    err   = err_q;
  end

  always_comb begin
    state_d = state_q;
    prec_d  = prec_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = 1'b0;
`ifdef MP_ALU_MUL_EN
    mul_acc_d = mul_acc_q;
    mul_idx_d = mul_idx_q;
    msb       = mask ^ (mask >> 1);
    mul_add   = b_q[mul_idx_q] ? ({{MaxW{1'b0}}, a_q} << mul_idx_q) : '0;
`endif
    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_fire) begin
            if (prec_ok && op_legal(op)) begin
              prec_d     = prec;
              op_d       = op;
              a_d        = '0;
              a_d[7:0]   = in_data;
              b_d        = '0;
              if (prec == '0) begin
                state_d = StLoadB;
                cnt_d   = '0;
              end else begin
                state_d = StLoadA;
                cnt_d   = CW'(1);
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StLoadA: begin
          if (in_fire) begin
            for (int i = 0; i < int'(MAX_BYTES); i++) begin
              if (i == int'(cnt_q)) a_d[8*i +: 8] = in_data;
            end
            if (last_byte) begin
              state_d = StLoadB;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        StLoadB: begin
          if (in_fire) begin
            for (int i = 0; i < int'(MAX_BYTES); i++) begin
              if (i == int'(cnt_q)) b_d[8*i +: 8] = in_data;
            end
            if (last_byte) begin
              state_d = StExec;
              cnt_d   = '0;
`ifdef MP_ALU_MUL_EN
              mul_acc_d = '0;
              mul_idx_d = '0;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        StExec: begin
`ifdef MP_ALU_MUL_EN
          if (op_q == OP_MUL) begin
            // one multiplier bit per cycle; finishes after W cycles
            mul_acc_d = mul_acc_q + mul_add;
            mul_idx_d = mul_idx_q + SW'(1);
            if (mul_idx_q == sh_mask) begin
              res_d         = mul_acc_d[MaxW-1:0] & mask;
              flags_d       = '0;
              flags_d[FL_C] = |(mul_acc_d & ~{{MaxW{1'b0}}, mask});
              flags_d[FL_V] = flags_d[FL_C];
              flags_d[FL_Z] = ((mul_acc_d[MaxW-1:0] & mask) == '0);
              flags_d[FL_N] = |(mul_acc_d[MaxW-1:0] & msb);
              state_d       = StDrain;
              cnt_d         = '0;
            end
          end else
`endif
          begin
            res_d   = core_res;
            flags_d = core_flags;
            state_d = StDrain;
            cnt_d   = '0;
          end
        end
        StDrain: begin
          if (out_fire) begin
            if (last_byte) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      prec_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

`ifdef MP_ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_acc_q <= '0;
      mul_idx_q <= '0;
    end else begin
      mul_acc_q <= mul_acc_d;
      mul_idx_q <= mul_idx_d;
    end
  end
`endif

endmodule
